// File: rtl/tone_gen_poly.sv
// Polyphonic-keyboard style square-wave tone generator: one note at a time,
// with octave scaling, retrigger and optional sustain tail after release.
module tone_gen_poly #(
  parameter int CNT_W       = 19,
  parameter int SUSTAIN_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_on,
  input  logic       key_off,
  input  logic [3:0] note,
  input  logic [2:0] octave,
  input  logic       sustain_en,
  output logic       speaker,
  output logic       playing,
  output logic [3:0] cur_note,
  output logic       bad_note
);

  localparam int TAIL_W = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;

  // Octave-4 half-periods in 50 MHz clock cycles.
  function automatic logic [16:0] base_half(input logic [3:0] n);
    case (n)
      4'd0:    base_half = 17'd95556;
      4'd1:    base_half = 17'd90193;
      4'd2:    base_half = 17'd85131;
      4'd3:    base_half = 17'd80353;
      4'd4:    base_half = 17'd75843;
      4'd5:    base_half = 17'd71586;
      4'd6:    base_half = 17'd67568;
      4'd7:    base_half = 17'd63776;
      4'd8:    base_half = 17'd60197;
      4'd9:    base_half = 17'd56818;
      4'd10:   base_half = 17'd53629;
      4'd11:   base_half = 17'd50619;
      default: base_half = 17'd0;
    endcase
  endfunction

  state_t             r_state;
  logic [CNT_W-1:0]   r_half;
  logic [CNT_W-1:0]   r_cnt;
  logic [TAIL_W-1:0]  r_tail;
  logic               r_sus;
  logic               r_spk;
  logic               r_playing;
  logic [3:0]         r_note;
  logic               r_bad;

  logic               w_note_ok;
  logic               w_accept;
  logic               w_reject;
  logic               w_release;
  logic [2:0]         w_oct_c;
  logic [CNT_W-1:0]   w_half_new;
  logic               w_wrap;
  logic [CNT_W-1:0]   w_cnt_adv;
  logic               w_spk_adv;
  logic               w_tail_end;

  assign w_note_ok  = (note <= 4'd11);
  assign w_accept   = key_on & w_note_ok;
  assign w_reject   = key_on & ~w_note_ok;
  // A same-cycle key_on always wins, so key_off only counts on its own.
  assign w_release  = key_off & ~key_on;
  assign w_oct_c    = (octave > 3'd4) ? 3'd4 : octave;
  assign w_half_new = (CNT_W'(base_half(note)) << 2) >> w_oct_c;

  assign w_wrap     = (r_cnt == r_half - CNT_W'(1));
  assign w_cnt_adv  = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign w_spk_adv  = r_spk ^ w_wrap;
  assign w_tail_end = (r_tail == TAIL_W'(SUSTAIN_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_half    <= '0;
      r_cnt     <= '0;
      r_tail    <= '0;
      r_sus     <= 1'b0;
      r_spk     <= 1'b0;
      r_playing <= 1'b0;
      r_note    <= 4'd0;
      r_bad     <= 1'b0;
    end else begin
      r_bad <= w_reject;
      if (w_accept) begin
        // Start or retrigger: relatch and restart the waveform from low.
        r_state   <= PLAY;
        r_playing <= 1'b1;
        r_half    <= w_half_new;
        r_note    <= note;
        r_sus     <= sustain_en;
        r_cnt     <= '0;
        r_spk     <= 1'b0;
        r_tail    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
            r_spk <= 1'b0;
          end
          PLAY: begin
            if (w_release && !r_sus) begin
              r_state   <= IDLE;
              r_playing <= 1'b0;
              r_cnt     <= '0;
              r_spk     <= 1'b0;
            end else begin
              if (w_release) begin
                r_state <= SUSTAIN;
                r_tail  <= '0;
              end
              r_cnt <= w_cnt_adv;
              r_spk <= w_spk_adv;
            end
          end
          SUSTAIN: begin
            if (w_tail_end) begin
              r_state   <= IDLE;
              r_playing <= 1'b0;
              r_cnt     <= '0;
              r_spk     <= 1'b0;
              r_tail    <= '0;
            end else begin
              r_tail <= r_tail + TAIL_W'(1);
              r_cnt  <= w_cnt_adv;
              r_spk  <= w_spk_adv;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_playing <= 1'b0;
            r_cnt     <= '0;
            r_spk     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign speaker  = r_spk;
  assign playing  = r_playing;
  assign cur_note = r_note;
  assign bad_note = r_bad;

endmodule

// File: doc/tone_gen_poly.md
TONE_GEN_POLY -- requirements
Module: tone_gen_poly

Interface
REQ-001 Parameter CNT_W, default 19, width of the half-period counter and the half-period value.
REQ-002 Parameter SUSTAIN_CYC, default 25_000_000, number of clk cycles of tail after release (0.5 s at 50 MHz).
REQ-003 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_on  input  1  one-cycle strobe: start or retrigger the note on note/octave.
REQ-006 key_off  input  1  one-cycle strobe: release the current note.
REQ-007 note  input  4  semitone index 0=C .. 11=B; 12-15 invalid.
REQ-008 octave  input  3  0..4 selects octave 2..6; values 5-7 clamp to 4.
REQ-009 sustain_en  input  1  1 = tail of SUSTAIN_CYC after release; 0 = stop immediately.
REQ-010 speaker  output  1  square-wave tone, registered.
REQ-011 playing  output  1  high in PLAY or SUSTAIN.
REQ-012 cur_note  output  4  latched note index of the sounding tone.
REQ-013 bad_note  output  1  one-cycle pulse on rejected key_on.

Function
REQ-014 The block SHALL hold a constant base table of octave-4 half-periods (clk cycles): C 95556, C# 90193, D 85131, D# 80353, E 75843, F 71586, F# 67568, G 63776, G# 60197, A 56818, A# 53629, B 50619.
REQ-015 The half-period SHALL be half = (BASE[note] << 2) >> oct_c, oct_c = min(octave,4), computed at CNT_W bits with no truncation for default CNT_W.
REQ-016 half, cur_note and sustain_en SHALL be latched only on an accepted key_on; input changes at other times SHALL have no effect.
REQ-017 States SHALL be IDLE, PLAY, SUSTAIN.
REQ-018 IDLE -> PLAY on key_on with note <= 11.
REQ-019 PLAY -> SUSTAIN on key_off when latched sustain_en=1; PLAY -> IDLE on key_off when latched sustain_en=0.
REQ-020 SUSTAIN -> IDLE when the tail counter reaches SUSTAIN_CYC-1; SUSTAIN -> PLAY on accepted key_on.
REQ-021 Accepted key_on in PLAY or SUSTAIN SHALL retrigger: relatch, counter := 0, speaker := 0, tail counter := 0, state := PLAY.
REQ-022 key_on with note >= 12 SHALL be ignored in every state and SHALL pulse bad_note for exactly one cycle, the cycle after the strobe.
REQ-023 key_on and key_off in the same cycle: key_on SHALL take priority and key_off SHALL be dropped.
REQ-024 key_off in IDLE, or in SUSTAIN, SHALL be ignored.
REQ-025 In PLAY and SUSTAIN the counter SHALL count 0..half-1, wrap to 0, and toggle speaker on the wrap cycle; each speaker level lasts exactly half cycles.
REQ-026 The first toggle after an accepted key_on SHALL occur half cycles after the cycle the strobe is sampled.
REQ-027 On entry to IDLE, speaker SHALL be driven 0 on the same edge, and the counter SHALL be 0.
REQ-028 playing SHALL update on the same edge as the state register.
REQ-029 cur_note SHALL retain its last value in IDLE.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state IDLE, speaker 0, playing 0, cur_note 0, bad_note 0, all counters 0, half 0.
REQ-031 Reset asserted mid-note SHALL silence the output immediately; the first key_on after rst_n rises SHALL behave as from power-up.

Verification
REQ-032 key_on, note=10, octave=2 -> speaker toggles every 53629 cycles; playing=1; cur_note=10.
REQ-033 note=0, octave=0 -> half=382224; note=11, octave=7 -> half=12654 (clamped to oct 4).
REQ-034 sustain_en=1, SUSTAIN_CYC overridden to 1000, key_off -> toggling continues 1000 cycles, then speaker=0, playing=0; with sustain_en=0 -> speaker=0, playing=0 the edge after key_off.
REQ-035 Retrigger A(9) -> E(4) mid-period -> speaker forced 0 that edge, next toggle exactly 75843 cycles later.
REQ-036 key_on with note=13 while playing A -> bad_note one-cycle pulse, A continues undisturbed; key_on and key_off together -> note (re)starts, no release.
REQ-037 rst_n pulled low mid-PLAY -> speaker=0, playing=0 without a clock edge; key_on after release plays correctly.
